// File: rtl/text_buffer_pkg.sv
// text_buffer_pkg: shared types and constants for the text-mode character store.
//   cmd_op_e : host command encoding (CLEAR_ALL, SCROLL_UP, CLEAR_ROW, NOP)
//   state_e  : fill-engine FSM states
//   DEFAULT_BLANK : fill value, space in light grey on black
package text_buffer_pkg;

  typedef enum logic [1:0] {
    CMD_CLEAR_ALL = 2'b00,
    CMD_SCROLL_UP = 2'b01,
    CMD_CLEAR_ROW = 2'b10,
    CMD_NOP       = 2'b11
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  localparam logic [15:0] DEFAULT_BLANK = 16'h0720;

endpackage

// File: rtl/text_buffer_mem.sv
// text_buffer_mem: simple dual-port RAM, one write port and one read port.
// Read-first on a same-address collision, optional output register.
//   clk, rst_n        : clock, async active-low reset (read registers only)
//   we, waddr, wdata  : write port
//   re, raddr         : read request and address
//   rdata             : read data, latency 1 + OUT_REG
module text_buffer_mem #(
  parameter int AW      = 10,
  parameter int DATA_W  = 16,
  parameter int OUT_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // No reset on the array so it maps onto block RAM.
  logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Non-blocking update of the array makes this read see the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rd_q <= '0;
    else if (re) rd_q <= mem_q[raddr];
  end

  generate
    if (OUT_REG != 0) begin : gen_out_reg
      logic [DATA_W-1:0] out_q;
      logic [DATA_W-1:0] out_d;
      always_comb out_d = rd_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= out_d;
      end
      assign rdata = out_q;
    end else begin : gen_no_out_reg
      assign rdata = rd_q;
    end
  endgenerate

endmodule

// File: rtl/text_buffer.sv
// text_buffer: character/attribute store with host write port, blank-fill
// engine, row-circular scrolling and a registered video read port.
//   rd_en/rd_col/rd_row -> rd_data/rd_valid : video read, latency 1 + OUT_REG
//   wr_en/wr_col/wr_row/wr_data, wr_ready   : host cell write
//   cmd_valid/cmd_op/cmd_row, cmd_ready     : CLEAR_ALL / SCROLL_UP / CLEAR_ROW / NOP
//   busy    : fill engine running
//   top_row : physical row shown as logical row 0
module text_buffer
  import text_buffer_pkg::*;
#(
  parameter int                 COLS    = 32,
  parameter int                 ROWS    = 32,
  parameter int                 DATA_W  = 16,
  parameter logic [DATA_W-1:0]  BLANK   = DATA_W'(DEFAULT_BLANK),
  parameter int                 OUT_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_en,
  input  logic [$clog2(COLS)-1:0]    rd_col,
  input  logic [$clog2(ROWS)-1:0]    rd_row,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       wr_en,
  output logic                       wr_ready,
  input  logic [$clog2(COLS)-1:0]    wr_col,
  input  logic [$clog2(ROWS)-1:0]    wr_row,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [$clog2(ROWS)-1:0]    cmd_row,
  output logic                       busy,
  output logic [$clog2(ROWS)-1:0]    top_row
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = CW + RW;
  localparam int VW = OUT_REG + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   fill_ptr_q, fill_ptr_d;
  logic [AW-1:0]   fill_end_q, fill_end_d;
  logic [RW-1:0]   top_row_q, top_row_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic [VW-1:0]   vld_q, vld_d;

  logic [RW-1:0]   clr_row;
  logic [RW-1:0]   wr_phys;
  logic [RW-1:0]   rd_phys;
  logic            fill_active;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign clr_row = cmd_row + top_row_q;
  assign wr_phys = wr_row + top_row_q;
  assign rd_phys = rd_row + top_row_q;

  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    fill_end_d = fill_end_q;
    top_row_d  = top_row_q;
    case (state_q)
      ST_IDLE: begin
        // ready_q is high exactly in IDLE, so cmd_valid here means accepted.
        if (cmd_valid) begin
          case (cmd_op_e'(cmd_op))
            CMD_CLEAR_ALL: begin
              top_row_d  = '0;
              fill_ptr_d = '0;
              fill_end_d = '1;
              state_d    = ST_FILL;
            end
            CMD_SCROLL_UP: begin
              // Old top row becomes the new bottom line and is blanked.
              top_row_d  = top_row_q + RW'(1);
              fill_ptr_d = {top_row_q, {CW{1'b0}}};
              fill_end_d = {top_row_q, {CW{1'b1}}};
              state_d    = ST_FILL;
            end
            CMD_CLEAR_ROW: begin
              fill_ptr_d = {clr_row, {CW{1'b0}}};
              fill_end_d = {clr_row, {CW{1'b1}}};
              state_d    = ST_FILL;
            end
            default: ;
          endcase
        end
      end
      ST_FILL: begin
        fill_ptr_d = fill_ptr_q + AW'(1);
        if (fill_ptr_q == fill_end_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d == ST_FILL);
    ready_d = (state_d == ST_IDLE);
    // Shift rd_en into the valid pipeline, one stage per read latency cycle.
    vld_d   = VW'({vld_q, rd_en});
  end

  // Reset lands in a whole-memory fill so the contents are always defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      fill_ptr_q <= '0;
      fill_end_q <= '1;
      top_row_q  <= '0;
      busy_q     <= 1'b1;
      ready_q    <= 1'b0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_ptr_q <= fill_ptr_d;
      fill_end_q <= fill_end_d;
      top_row_q  <= top_row_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      vld_q      <= vld_d;
    end
  end

  // Host writes are blocked during a fill, so the fill never contends.
  assign fill_active = (state_q == ST_FILL);
  assign mem_we      = fill_active | (wr_en & ready_q);
  assign mem_waddr   = fill_active ? fill_ptr_q : {wr_phys, wr_col};
  assign mem_wdata   = fill_active ? BLANK : wr_data;

  text_buffer_mem #(
    .AW      (AW),
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (rd_en),
    .raddr ({rd_phys, rd_col}),
    .rdata (rd_data)
  );

  assign rd_valid  = vld_q[OUT_REG];
  assign busy      = busy_q;
  assign wr_ready  = ready_q;
  assign cmd_ready = ready_q;
  assign top_row   = top_row_q;

endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: randomized self-checking bench for text_buffer against a
// logical-screen model (rows shift on scroll, no physical mapping).
module tb_text_buffer;

  localparam int COLS = 32;
  localparam int ROWS = 32;
  localparam logic [15:0] BLK = 16'h0720;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_col = '0, rd_row = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_en = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_col = '0, wr_row = '0;
  logic [15:0] wr_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b11;
  logic [4:0]  cmd_row = '0;
  logic        busy;
  logic [4:0]  top_row;

  int checks = 0;
  int failures = 0;

  logic [15:0] scr [ROWS][COLS];
  int          top_m = 0;

  always #5 clk = ~clk;

  text_buffer #(.COLS(COLS), .ROWS(ROWS), .DATA_W(16), .BLANK(BLK), .OUT_REG(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_col(rd_col), .rd_row(rd_row), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_row(cmd_row),
    .busy(busy), .top_row(top_row)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---- reference model, logical screen coordinates ----
  task automatic m_clear_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = BLK;
    top_m = 0;
  endtask

  task automatic m_clear_row(input int row);
    for (int c = 0; c < COLS; c++) scr[row][c] = BLK;
  endtask

  task automatic m_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
    m_clear_row(ROWS - 1);
    top_m = (top_m + 1) % ROWS;
  endtask

  task automatic m_cmd(input int op, input int row);
    case (op)
      0: m_clear_all();
      1: m_scroll();
      2: m_clear_row(row);
      default: ;
    endcase
  endtask

  function automatic int fill_len(input int op);
    if (op == 0) return ROWS * COLS;
    if (op == 3) return 0;
    return COLS;
  endfunction

  // Tick until cmd_ready, returning the number of edges it took.
  task automatic wait_ready(output int n);
    n = 0;
    while (!cmd_ready && n < 5000) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_read(input int r, input int c);
    rd_en = 1'b1; rd_row = 5'(r); rd_col = 5'(c);
    tick();
    rd_en = 1'b0;
    chk("rd_valid_early", rd_valid, 0);
    tick();
    chk("rd_valid", rd_valid, 1);
    chk($sformatf("rd(%0d,%0d)", c, r), rd_data, scr[r][c]);
    $display("read  row=%0d col=%0d data=%h top=%0d", r, c, rd_data, top_row);
  endtask

  task automatic do_write(input int r, input int c, input logic [15:0] d);
    int n;
    wr_en = 1'b1; wr_row = 5'(r); wr_col = 5'(c); wr_data = d;
    wait_ready(n);
    tick();
    wr_en = 1'b0;
    scr[r][c] = d;
    $display("write row=%0d col=%0d data=%h", r, c, d);
  endtask

  task automatic do_cmd(input int op, input int row);
    int n;
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_row = 5'(row);
    wait_ready(n);
    tick();
    cmd_valid = 1'b0;
    m_cmd(op, row);
    chk("top_row", top_row, top_m);
    chk("busy_after_accept", busy, (op != 3));
    wait_ready(n);
    chk("fill_cycles", n, fill_len(op));
    chk("busy_idle", busy, 0);
    $display("cmd   op=%0d row=%0d fill=%0d top=%0d", op, row, n, top_row);
  endtask

  initial begin
    int n;
    int r, c;
    m_clear_all();

    // ---- reset and initial full clear ----
    repeat (3) tick();
    chk("rst_busy", busy, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_top", top_row, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    wait_ready(n);
    chk("init_clear_cycles", n, ROWS * COLS);
    chk("init_wr_ready", wr_ready, 1);
    $display("init  clear=%0d cycles", n);
    for (int i = 0; i < 6; i++) do_read($urandom_range(0, 31), $urandom_range(0, 31));

    // ---- directed: write then read next cycle ----
    do_write(3, 5, 16'h0F41);
    do_read(3, 5);

    // ---- directed: scroll moves logical row 1 to row 0 ----
    do_write(1, 0, 16'h0141);
    do_cmd(1, 0);
    do_read(0, 0);
    for (int cc = 0; cc < COLS; cc += 7) do_read(31, cc);

    // ---- 31 more scrolls wrap top_row back to 0, 33 cycles each ----
    for (int i = 0; i < ROWS - 1; i++) do_cmd(1, 0);
    chk("top_wrap", top_row, 0);

    // ---- held write/cmd during CLEAR_ROW 7 ----
    for (int cc = 0; cc < 4; cc++) do_write(7, cc, 16'(16'h1100 + cc));
    do_write(6, 2, 16'h2222);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_row = 5'd7;
    tick();
    m_cmd(2, 7);
    cmd_op = 2'd3;
    wr_en = 1'b1; wr_row = 5'd9; wr_col = 5'd4; wr_data = 16'h1234;
    n = 0;
    while (!wr_ready && n < 5000) begin
      if (n == 0 || n == 15) begin
        chk("held_wr_ready", wr_ready, 0);
        chk("held_cmd_ready", cmd_ready, 0);
      end
      tick();
      n++;
    end
    chk("held_wait", n, COLS);
    tick();
    wr_en = 1'b0; cmd_valid = 1'b0;
    scr[9][4] = 16'h1234;
    chk("nop_idle", busy, 0);
    do_read(9, 4);
    do_read(7, 1);
    do_read(6, 2);

    // ---- simultaneous write and CLEAR_ROW to the same row ----
    wr_en = 1'b1; wr_row = 5'd7; wr_col = 5'd2; wr_data = 16'hBEEF;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_row = 5'd7;
    tick();
    wr_en = 1'b0; cmd_valid = 1'b0;
    scr[7][2] = 16'hBEEF;
    m_cmd(2, 7);
    wait_ready(n);
    chk("same_cycle_fill", n, COLS);
    do_read(7, 2);

    // ---- randomized traffic ----
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 19);
      r = $urandom_range(0, 31);
      c = $urandom_range(0, 31);
      if (k < 10)      do_write(r, c, 16'($urandom));
      else if (k < 17) do_read(r, c);
      else if (k == 17) do_cmd(1, 0);
      else if (k == 18) do_cmd(2, r);
      else             do_cmd(($urandom_range(0, 3) == 0) ? 0 : 3, 0);
    end
    for (int i = 0; i < 20; i++) do_read($urandom_range(0, 31), $urandom_range(0, 31));

    // ---- reset in the middle of a CLEAR_ROW ----
    do_cmd(1, 0);
    do_write(4, 4, 16'h5A5A);
    do_read(4, 4);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_row = 5'd3;
    wait_ready(n);
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_top", top_row, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_clear_all();
    wait_ready(n);
    chk("rerun_clear_cycles", n, ROWS * COLS);
    $display("reset mid-fill, clear=%0d cycles", n);
    do_read(4, 4);
    for (int i = 0; i < 6; i++) do_read($urandom_range(0, 31), $urandom_range(0, 31));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_buffer.md
# text_buffer

Parametrised character/attribute store for the VGA text-mode pipeline. It replaces the fixed, init-only text RAM with four capabilities: a host write port, a hardware clear engine, row-circular scrolling and a registered video read port. The video timing/glyph path reads from it every character cell. A host-side writer (UART console, test-pattern FSM) owns the write and command ports.

## Interface
Parameters:
- `COLS`, 32: columns per row; power of two.
- `ROWS`, 32: rows; power of two.
- `DATA_W`, 16: cell width, `{attr[15:8], char[7:0]}`.
- `BLANK`, 16'h0720: fill value for clears (space, light grey on black).
- `OUT_REG`, 1: 1 adds the RAM output register, for read latency 2; 0 gives latency 1.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `rd_en`, in, 1: video read request.
- `rd_col`, in, log2(COLS): logical column.
- `rd_row`, in, log2(ROWS): logical row (screen line).
- `rd_data`, out, DATA_W: cell data.
- `rd_valid`, out, 1: `rd_data` valid.
- `wr_en`, in, 1: host write request.
- `wr_ready`, out, 1: write accepted when `wr_en && wr_ready`.
- `wr_col`, in, log2(COLS): logical column.
- `wr_row`, in, log2(ROWS): logical row.
- `wr_data`, in, DATA_W: cell data.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`, in, 2: 00 CLEAR_ALL, 01 SCROLL_UP, 10 CLEAR_ROW, 11 NOP.
- `cmd_row`, in, log2(ROWS): logical row for CLEAR_ROW.
- `busy`, out, 1: fill engine active.
- `top_row`, out, log2(ROWS): physical row currently displayed as logical row 0.

## Operation
- Address mapping: physical row = (logical row + `top_row`) mod ROWS. Address = {phys_row, col}, depth ROWS*COLS.
- FSM states:
  - IDLE: `wr_ready = cmd_ready = 1`, `busy = 0`.
  - FILL: writes BLANK at `fill_ptr` each cycle, from `fill_start` to `fill_end` inclusive, then returns to IDLE. `wr_ready = cmd_ready = 0`, `busy = 1`.
- After reset, the FSM enters FILL over the whole memory (CLEAR_ALL), so the memory contents are defined.
- CLEAR_ALL: `top_row <= 0` at acceptance; fills the whole memory; ROWS*COLS cycles.
- SCROLL_UP: at acceptance `top_row <= top_row+1` (wraps ROWS-1 -> 0). The engine then fills the old top physical row, which is now logical row ROWS-1; COLS cycles.
- CLEAR_ROW: fills physical row (`cmd_row` + `top_row`) mod ROWS, using `top_row` as sampled at acceptance; COLS cycles.
- NOP: accepted, no state change, FSM stays in IDLE.
- A write and a command accepted in the same cycle: the write commits at that edge and the fill starts the next cycle. A fill therefore overwrites a same-cycle write to the filled range.
- Reads are never blocked, including during FILL. Read/write collision on the same address returns old data (read-first).
- Reset mid-operation: any fill is aborted, `top_row` goes to 0 and a full CLEAR_ALL restarts on release.

## Timing
- Reset values:
  - `rd_data` = 0, `rd_valid` = 0.
  - `busy` = 1, `wr_ready` = 0, `cmd_ready` = 0.
  - `top_row` = 0.
  - FSM = FILL (CLEAR_ALL), `fill_ptr` = 0.
- Read latency: `rd_en` at edge N gives `rd_data`/`rd_valid` at edge N+1+OUT_REG. `rd_valid` is a pipelined copy of `rd_en`.
- Read address mapping uses `top_row` at the cycle `rd_en` is sampled.
- Write commits at the accepting edge; a read issued the next cycle returns the new data.
- Command accepted at edge N:
  - `busy` is high from N+1 for exactly L cycles (L = COLS or ROWS*COLS).
  - `cmd_ready` and `wr_ready` are high again at edge N+1+L.
  - `top_row` updates at edge N+1.
- `cmd_valid`/`wr_en` held while not ready: no effect. The requester must hold its signals (valid/ready rule; no drop requirement on the bench).

## Structure
- Package `text_buffer_pkg`: `cmd_op` enum (CMD_CLEAR_ALL, CMD_SCROLL_UP, CMD_CLEAR_ROW, CMD_NOP), FSM state enum, default BLANK constant.
- Sub-module `text_buffer_mem`: simple dual-port RAM (one write port, one read port, read-first, optional output register, no reset on the array). It must infer one SDPB per 1024x16 on GW1N.
- Top level contains the FSM, fill counter, `top_row` register, address mapping and the write mux (fill has priority over the host port by construction, since the host port is blocked during fill).

## Test plan
- Reset release, COLS=ROWS=32: `busy` is high for exactly 1024 cycles, then `wr_ready = 1`. Random reads all return 16'h0720 with `rd_valid` 2 cycles after `rd_en`.
- Write (col 5, row 3) = 16'h0F41, then read (5,3) on the next cycle: `rd_data` = 16'h0F41 at +2 cycles. With OUT_REG=0: at +1 cycle.
- Write logical (0,1) = 16'h0141, then SCROLL_UP:
  - `top_row` = 1 and `busy` is high for 32 cycles.
  - Afterwards logical (0,0) = 16'h0141 and all of logical row 31 = 16'h0720.
- 32 consecutive SCROLL_UP commands: `top_row` wraps back to 0. Every scroll takes 33 cycles, command to next accept.
- During CLEAR_ROW (`cmd_row` = 7):
  - `cmd_valid` and `wr_en` stay held with `cmd_ready = wr_ready = 0`, and memory outside row 7 is unchanged.
  - The held write commits on the first IDLE cycle.
  - Simultaneous write to (2,7) plus CLEAR_ROW 7 leaves (2,7) = 16'h0720.
- `rst_n` low for 1 cycle in the middle of a CLEAR_ROW: outputs take their reset values asynchronously, `top_row` = 0, and a full 1024-cycle clear runs after release.
